// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: two-port 32-bit request bus plus byte-wide synchronous RAM bus.
// The master side is the requester/RAM, the slave side is the controller.
interface mem_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic [3:0]        rw_flag;
    logic [63:0]       addr;
    logic [63:0]       write_data;
    logic [7:0]        write_mask;
    logic [63:0]       read_data;
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_wr;

    modport master (
        output rw_flag, addr, write_data, write_mask, mem_din,
        input  read_data, busy, done, mem_a, mem_dout, mem_wr
    );

    modport slave (
        input  rw_flag, addr, write_data, write_mask, mem_din,
        output read_data, busy, done, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates two 32-bit request ports (port 0 wins) onto a byte-wide
// synchronous RAM, one byte per cycle, with a one-cycle done pulse per port.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input logic       clk_i,
    input logic       rst_i,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              p_q, p_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       wd_q, wd_d;
    logic [3:0]        wm_q, wm_d;
    logic [31:0]       word_q, word_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              act0, act1, sel;
    logic [1:0]        flag;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] ak;
    logic              unused_addr;

    assign act0 = bus.rw_flag[1:0] == 2'd1 || bus.rw_flag[1:0] == 2'd2;
    assign act1 = bus.rw_flag[3:2] == 2'd1 || bus.rw_flag[3:2] == 2'd2;
    assign sel  = !act0;
    assign flag = sel ? bus.rw_flag[3:2] : bus.rw_flag[1:0];
    // read data for address k-1 arrives while the counter shows k
    assign idx  = k_q[1:0] - 2'd1;
    assign ak   = a_q + ADDR_W'(k_q[1:0]);

    always_comb begin
        state_d = state_q;
        k_d     = k_q + 3'd1;
        p_d     = p_q;
        a_d     = a_q;
        wd_d    = wd_q;
        wm_d    = wm_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                k_d = 3'd0;
                if (act0 || act1) begin
                    p_d     = sel;
                    a_d     = bus.addr[{sel, 5'd0} +: ADDR_W];
                    wd_d    = bus.write_data[{sel, 5'd0} +: 32];
                    wm_d    = bus.write_mask[{sel, 2'd0} +: 4];
                    state_d = flag == 2'd1 ? RD : WR;
                end
            end
            RD: begin
                if (k_q != 3'd0) word_d[{idx, 3'd0} +: 8] = bus.mem_din;
                if (k_q == 3'd4) begin
                    state_d                    = DONE;
                    rdata_d[{p_q, 5'd0} +: 32] = word_d;
                end
            end
            WR:      state_d = k_q == 3'd3 ? DONE : WR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            p_q     <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            wm_q    <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            wm_q    <= wm_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.busy      = (state_q == RD || state_q == WR) ? (p_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.done      = state_q == DONE ? (p_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.mem_a     = (state_q == WR || (state_q == RD && !k_q[2])) ? ak : '0;
    assign bus.mem_dout  = state_q == WR ? wd_q[{k_q[1:0], 3'd0} +: 8] : 8'd0;
    assign bus.mem_wr    = state_q == WR && wm_q[k_q[1:0]];
    assign unused_addr   = ^{bus.addr[31:ADDR_W], bus.addr[63:32+ADDR_W]};
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives directed and random two-port traffic, predicts a cycle
// timeline of every output from the transaction timing rules, and compares each cycle.
module tb_mem_ctrl;
    localparam int AW = 17;
    localparam int NC = 8192;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    mem_ctrl_if #(.ADDR_W(AW)) bus ();
    mem_ctrl #(.ADDR_W(AW)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    bit [7:0] ram [0:(1<<AW)-1];
    bit [7:0] sh  [0:(1<<AW)-1];

    always @(posedge clk_i) begin
        if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a];
    end

    bit [1:0]    e_busy [NC];
    bit [1:0]    e_done [NC];
    bit [AW-1:0] e_ma   [NC];
    bit          e_wr   [NC];
    bit [7:0]    e_do   [NC];
    bit          e_ma_dc[NC];
    bit          e_do_dc[NC];
    bit          e_ld   [NC];
    bit          e_p    [NC];
    bit [31:0]   e_word [NC];

    int          cyc = 0;
    bit          rst_q;
    bit          chk_en;
    logic [63:0] m_rd;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk_i) begin
        cyc   <= cyc + 1;
        rst_q <= rst_i;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en && cyc < NC) begin
            if (rst_q) m_rd = '0;
            if (e_ld[cyc]) m_rd[32*e_p[cyc] +: 32] = e_word[cyc];
            check("busy", 64'(bus.busy), 64'(e_busy[cyc]));
            check("done", 64'(bus.done), 64'(e_done[cyc]));
            check("mem_wr", 64'(bus.mem_wr), 64'(e_wr[cyc]));
            check("read_data", bus.read_data, m_rd);
            check("busy_both", 64'(bus.busy == 2'b11), 64'd0);
            if (!e_ma_dc[cyc]) check("mem_a", 64'(bus.mem_a), 64'(e_ma[cyc]));
            if (!e_do_dc[cyc]) check("mem_dout", 64'(bus.mem_dout), 64'(e_do[cyc]));
        end
    end

    // Fill the expected timeline for one accepted transaction visible in IDLE at cycle n.
    task automatic sched(input int n, input bit p, input bit wr, input bit [AW-1:0] a,
                         input bit [31:0] d, input bit [3:0] m, output int dn);
        bit [31:0]   w;
        bit [AW-1:0] ak;
        bit [1:0]    pb;
        w  = '0;
        pb = p ? 2'b10 : 2'b01;
        for (int k = 0; k < 4; k++) begin
            ak               = a + AW'(k);
            e_busy[n+1+k]    = pb;
            e_ma[n+1+k]      = ak;
            if (wr) begin
                e_wr[n+1+k] = m[k];
                e_do[n+1+k] = d[8*k +: 8];
                if (m[k]) sh[ak] = d[8*k +: 8];
            end else begin
                e_do_dc[n+1+k] = 1'b1;
                w[8*k +: 8]    = sh[ak];
            end
        end
        if (wr) dn = n + 5;
        else begin
            e_busy[n+5]  = pb;
            e_ma_dc[n+5] = 1'b1;
            e_do_dc[n+5] = 1'b1;
            dn           = n + 6;
            e_ld[dn]     = 1'b1;
            e_p[dn]      = p;
            e_word[dn]   = w;
        end
        e_done[dn] = pb;
    endtask

    task automatic clr(input int c);
        e_busy[c]  = '0;
        e_done[c]  = '0;
        e_ma[c]    = '0;
        e_wr[c]    = 1'b0;
        e_do[c]    = '0;
        e_ma_dc[c] = 1'b0;
        e_do_dc[c] = 1'b0;
        e_ld[c]    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic run_pair(input bit [1:0] f0, input bit [1:0] f1, input bit [31:0] a0,
                            input bit [31:0] a1, input bit [31:0] d0, input bit [31:0] d1,
                            input bit [3:0] m0, input bit [3:0] m1);
        int n, dn;
        bit act0, act1;
        act0             = f0 == 2'd1 || f0 == 2'd2;
        act1             = f1 == 2'd1 || f1 == 2'd2;
        bus.rw_flag      = {f1, f0};
        bus.addr         = {a1, a0};
        bus.write_data   = {d1, d0};
        bus.write_mask   = {m1, m0};
        n                = cyc;
        if (act0) begin
            sched(n, 1'b0, f0 == 2'd2, a0[AW-1:0], d0, m0, dn);
            tick();
            bus.addr[31:0]       = $urandom;
            bus.write_data[31:0] = $urandom;
            bus.write_mask[3:0]  = 4'($urandom);
            wait_until(dn);
            bus.rw_flag[1:0] = 2'd0;
            n = dn + 1;
        end
        if (act1) begin
            wait_until(n);
            sched(n, 1'b1, f1 == 2'd2, a1[AW-1:0], d1, m1, dn);
            wait_until(n + 1);
            bus.addr[63:32]       = $urandom;
            bus.write_data[63:32] = $urandom;
            bus.write_mask[7:4]   = 4'($urandom);
            wait_until(dn);
            bus.rw_flag[3:2] = 2'd0;
        end
        bus.rw_flag = 4'd0;
        tick();
    endtask

    function automatic bit [31:0] ra();
        bit [AW-1:0] lo;
        lo = $urandom_range(0, 1) != 0 ? AW'(17'h100 + $urandom_range(0, 15))
                                       : AW'(17'h1FFFC + $urandom_range(0, 3));
        return {15'($urandom), lo};
    endfunction

    int      n, dn;
    bit [7:0] s2, s3;

    initial begin
        bus.rw_flag    = 4'b0101;
        bus.addr       = '0;
        bus.write_data = '0;
        bus.write_mask = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;
        run_pair(2'd1, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);

        run_pair(2'd2, 2'd0, 32'h10, 32'h0, 32'h12345678, 32'h0, 4'hF, 4'h0);
        run_pair(2'd0, 2'd1, 32'h0, 32'h10, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk_i);
        check("lit_p1_read", 64'(bus.read_data[63:32]), 64'h12345678);
        check("lit_p1_model", 64'(m_rd[63:32]), 64'h12345678);

        run_pair(2'd2, 2'd0, 32'h20, 32'h0, 32'hFFFFFFFF, 32'h0, 4'hF, 4'h0);
        run_pair(2'd2, 2'd0, 32'h20, 32'h0, 32'hAABBCCDD, 32'h0, 4'b0101, 4'h0);
        run_pair(2'd1, 2'd0, 32'h20, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk_i);
        check("lit_masked", 64'(bus.read_data[31:0]), 64'hFFBBFFDD);
        check("lit_masked_model", 64'(m_rd[31:0]), 64'hFFBBFFDD);

        run_pair(2'd0, 2'd2, 32'h0, 32'h1FFFE, 32'h0, 32'h44332211, 4'h0, 4'hF);
        run_pair(2'd1, 2'd1, 32'hABCBFFFE, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk_i);
        check("lit_wrap_p0", 64'(bus.read_data[31:0]), 64'h44332211);
        check("lit_wrap_p1", 64'(bus.read_data[63:32]), 64'h00004433);

        bus.rw_flag    = 4'b0010;
        bus.addr       = 64'h40;
        bus.write_data = 64'hDEADBEEF;
        bus.write_mask = 8'h0F;
        n  = cyc;
        s2 = sh[17'h42];
        s3 = sh[17'h43];
        sched(n, 1'b0, 1'b1, 17'h40, 32'hDEADBEEF, 4'hF, dn);
        sh[17'h42] = s2;
        sh[17'h43] = s3;
        for (int c = n + 3; c <= n + 6; c++) clr(c);
        wait_until(n + 2);
        rst_i       = 1'b1;
        bus.rw_flag = 4'd0;
        tick();
        rst_i = 1'b0;
        tick();
        run_pair(2'd1, 2'd0, 32'h40, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk_i);
        check("lit_rst_write", 64'(bus.read_data[31:0]), 64'h0000BEEF);

        for (int i = 0; i < 200 && cyc < NC - 40; i++) begin
            run_pair(2'($urandom), 2'($urandom), ra(), ra(), $urandom, $urandom,
                     4'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
